// File: rtl/mod_reduce_seq.sv
// Sequential modular reducer: folds C operand bits per cycle, MSB first (Horner),
// into a residue modulo the constant M, with optional negation of the result.
module mod_reduce_seq #(
  parameter int W = 300,
  parameter int C = 6,
  parameter int M = 4051,
  parameter int R = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_neg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [R-1:0] out_res,
  output logic         busy
);

  localparam int N  = (W + C - 1) / C;
  localparam int DW = N * C;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = R + C + 1;
  localparam logic [TW-1:0] M_T = TW'(M);

  typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic            neg_q, neg_d;
  logic [R-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [R-1:0]    res_q, res_d;
  logic            vld_q, vld_d;

  logic [TW-1:0]   fold_sum;
  logic [TW-1:0]   fold_rem;

  // acc*2**C + chunk < M*2**(C+1), so C+1 restoring subtract steps of M*2**k
  // (k = C..0) leave a value below M.
  always_comb begin
    fold_sum = {1'b0, acc_q, data_q[DW-1 -: C]};
    fold_rem = fold_sum;
    for (int k = C; k >= 0; k--) begin
      if (fold_rem >= (M_T << k)) fold_rem = fold_rem - (M_T << k);
    end
  end

  always_comb begin
    // NOTE: every _d takes its _q value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    data_d  = data_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = DW'(in_data);
          neg_d   = in_neg;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The operand shifts up so the next chunk is always at the top.
        acc_d  = fold_rem[R-1:0];
        data_d = data_q << C;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = FIN;
      end
      FIN: begin
        if (neg_q) res_d = (acc_q == '0) ? '0 : R'(M) - acc_q;
        else       res_d = acc_q;
        vld_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = vld_q;
  assign out_res   = res_q;

endmodule
